// File: rtl/fifo_read_core.sv
// fifo_read_core: read side of a FIFO with local storage; the writer owns and advances wrt_ptr.
// Ports:
//   rclk      - clock, all state updates on the rising edge
//   arst_n    - asynchronous active-low reset (read_ptr, data_out)
//   rd_en     - read request, accepted when not empty
//   wr_en     - write request, accepted when not full
//   data_in   - write data stored at wrt_ptr's address
//   wrt_ptr   - writer's binary pointer, MSB is the wrap bit
//   read_ptr  - binary read pointer, MSB is the wrap bit
//   data_out  - registered read data, holds between accepted reads
//   empty     - pointers identical
//   full      - addresses equal, wrap bits differ
module fifo_read_core #(
  parameter int SIZE    = 8,
  parameter int WIDTH   = 8,
  parameter int PTR_LEN = $clog2(SIZE)
) (
  input  logic               rclk,
  input  logic               arst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [PTR_LEN:0]   wrt_ptr,
  output logic [PTR_LEN:0]   read_ptr,
  output logic [WIDTH-1:0]   data_out,
  output logic               empty,
  output logic               full
);
  logic [WIDTH-1:0] r_mem [SIZE];
  logic [PTR_LEN:0] r_read_ptr;
  logic [WIDTH-1:0] r_data_out;
  logic             w_rd;
  logic             w_wr;
  assign empty    = r_read_ptr == wrt_ptr;
  assign full     = (r_read_ptr[PTR_LEN] != wrt_ptr[PTR_LEN]) &&
                    (r_read_ptr[PTR_LEN-1:0] == wrt_ptr[PTR_LEN-1:0]);
  assign w_rd     = rd_en && !empty;
  // storage has no reset, so writes are masked explicitly while reset is held
  assign w_wr     = wr_en && !full && arst_n;
  assign read_ptr = r_read_ptr;
  assign data_out = r_data_out;
  always_ff @(posedge rclk)
    if (w_wr) r_mem[wrt_ptr[PTR_LEN-1:0]] <= data_in;
  // a same-address read and write in one cycle returns the old word
  always_ff @(posedge rclk or negedge arst_n)
    if (!arst_n) begin
      r_read_ptr <= '0;
      r_data_out <= '0;
    end else if (w_rd) begin
      r_data_out <= r_mem[r_read_ptr[PTR_LEN-1:0]];
      r_read_ptr <= r_read_ptr + 1'b1;
    end
endmodule

// File: tb/tb_fifo_read_core.sv
// tb_fifo_read_core: directed scoreboard bench for fifo_read_core.
module tb_fifo_read_core;
  logic       rclk = 1'b0;
  logic       arst_n;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] data_in;
  logic [3:0] wrt_ptr;
  logic [3:0] read_ptr;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] q [$];
  logic [3:0] m_rptr;
  logic [3:0] m_wptr;
  logic [7:0] m_dout;
  fifo_read_core #(.SIZE(8), .WIDTH(8)) dut (
    .rclk(rclk), .arst_n(arst_n), .rd_en(rd_en), .wr_en(wr_en),
    .data_in(data_in), .wrt_ptr(wrt_ptr), .read_ptr(read_ptr),
    .data_out(data_out), .empty(empty), .full(full)
  );
  always #5 rclk = ~rclk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    check({tag, ".read_ptr"}, 32'(read_ptr), 32'(m_rptr));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == 8));
  endtask
  task automatic cycle(input string tag, input logic rd, input logic wr, input logic [7:0] d);
    int  pre;
    logic acc_r, acc_w;
    @(negedge rclk);
    rd_en   = rd;
    wr_en   = wr;
    data_in = d;
    wrt_ptr = m_wptr;
    pre     = q.size();
    acc_r   = rd && pre > 0;
    acc_w   = wr && pre < 8;
    @(posedge rclk);
    #1;
    if (acc_r) begin
      m_dout = q.pop_front();
      m_rptr = m_rptr + 4'd1;
    end
    if (acc_w) begin
      q.push_back(d);
      m_wptr = m_wptr + 4'd1;
    end
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wrt_ptr = m_wptr;
    #1;
    check_all(tag);
  endtask
  task automatic do_reset(input string tag);
    arst_n  = 1'b0;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    data_in = 8'h55;
    wrt_ptr = 4'd0;
    q.delete();
    m_rptr  = 4'd0;
    m_wptr  = 4'd0;
    m_dout  = 8'h00;
    #1;
    check_all({tag, ".async"});
    repeat (2) @(posedge rclk);
    #1;
    check_all({tag, ".held"});
    @(negedge rclk);
    rd_en  = 1'b0;
    wr_en  = 1'b0;
    arst_n = 1'b1;
  endtask
  initial begin
    arst_n  = 1'b1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    data_in = 8'h00;
    wrt_ptr = 4'd0;
    m_rptr  = 4'd0;
    m_wptr  = 4'd0;
    m_dout  = 8'h00;
    #2;
    do_reset("reset");
    cycle("wr_a1", 1'b0, 1'b1, 8'hA1);
    cycle("rd_a1", 1'b1, 1'b0, 8'h00);
    check("rd_a1.literal", 32'(data_out), 32'h0000_00A1);
    cycle("rd_empty", 1'b1, 1'b0, 8'h00);
    do_reset("reset2");
    for (int i = 0; i < 8; i++) cycle("fill", 1'b0, 1'b1, 8'h10 + 8'(i));
    check("fill.full", 32'(full), 32'd1);
    cycle("wr_when_full", 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b1, 1'b0, 8'h00);
    check("drain.last", 32'(data_out), 32'h17);
    cycle("rd_ninth", 1'b1, 1'b0, 8'h00);
    check("rd_ninth.ptr", 32'(read_ptr), 32'd8);
    for (int i = 0; i < 7; i++) cycle("pre_wrap_wr", 1'b0, 1'b1, 8'h20 + 8'(i));
    for (int i = 0; i < 7; i++) cycle("pre_wrap_rd", 1'b1, 1'b0, 8'h00);
    check("pre_wrap.ptr", 32'(read_ptr), 32'd15);
    cycle("wrap_wr", 1'b0, 1'b1, 8'h3C);
    check("wrap_wr.wptr", 32'(wrt_ptr), 32'd0);
    cycle("wrap_rd", 1'b1, 1'b0, 8'h00);
    check("wrap_rd.ptr", 32'(read_ptr), 32'd0);
    check("wrap_rd.empty", 32'(empty), 32'd1);
    cycle("rw_empty", 1'b1, 1'b1, 8'h44);
    cycle("rd_44", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cycle("refill", 1'b0, 1'b1, 8'h80 + 8'(i));
    cycle("rw_full_same_addr", 1'b1, 1'b1, 8'hEE);
    check("rw_full_same_addr.old", 32'(data_out), 32'h80);
    for (int i = 0; i < 3; i++) cycle("mid_rd", 1'b1, 1'b0, 8'h00);
    arst_n  = 1'b0;
    wrt_ptr = 4'd0;
    q.delete();
    m_rptr  = 4'd0;
    m_wptr  = 4'd0;
    m_dout  = 8'h00;
    #1;
    check_all("mid_reset");
    @(negedge rclk);
    arst_n = 1'b1;
    cycle("post_reset_wr", 1'b0, 1'b1, 8'h5A);
    cycle("post_reset_rd", 1'b1, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_read_core.md
FIFO_READ_CORE -- requirements
Module: fifo_read_core

Interface
REQ-001 SHALL have parameter SIZE, default 8, FIFO depth in words; power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-003 SHALL have parameter PTR_LEN, default $clog2(SIZE), memory address width.
REQ-004 SHALL have port rclk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rd_en, input, 1 bit: read request.
REQ-007 SHALL have port wr_en, input, 1 bit: write request.
REQ-008 SHALL have port data_in, input, WIDTH bits: write data.
REQ-009 SHALL have port wrt_ptr, input, PTR_LEN+1 bits: binary write pointer supplied by the writer; MSB is the wrap bit, low PTR_LEN bits are the write address.
REQ-010 SHALL have port read_ptr, output, PTR_LEN+1 bits: binary read pointer; MSB is the wrap bit.
REQ-011 SHALL have port data_out, output, WIDTH bits: registered read data.
REQ-012 SHALL have port empty, output, 1 bit: FIFO holds no data.
REQ-013 SHALL have port full, output, 1 bit: FIFO holds SIZE words.

Function
REQ-014 SHALL hold storage of SIZE words of WIDTH bits.
REQ-015 SHALL drive empty combinationally, high exactly when read_ptr == wrt_ptr (all PTR_LEN+1 bits).
REQ-016 SHALL drive full combinationally, high exactly when the MSBs of read_ptr and wrt_ptr differ and their low PTR_LEN bits are equal.
REQ-017 SHALL never assert empty and full at the same time.
REQ-018 SHALL perform a write on each rclk edge with wr_en=1 and full=0: mem[wrt_ptr[PTR_LEN-1:0]] <= data_in.
REQ-019 SHALL ignore writes with full=1; the memory is unchanged.
REQ-020 SHALL not advance the write pointer itself; wrt_ptr is owned by the writer.
REQ-021 SHALL perform a read on each rclk edge with rd_en=1 and empty=0: data_out <= mem[read_ptr[PTR_LEN-1:0]] and read_ptr <= read_ptr+1.
REQ-022 SHALL have one-cycle read latency: the word is visible on data_out after the accepting edge.
REQ-023 SHALL ignore reads with empty=1: read_ptr and data_out hold.
REQ-024 SHALL hold data_out between accepted reads.
REQ-025 SHALL increment read_ptr modulo 2^(PTR_LEN+1); after address SIZE-1 the low bits wrap to 0 and the MSB toggles.
REQ-026 SHALL allow a read while full=1 and a write while empty=1.
REQ-027 SHALL allow a simultaneous read and write in the same cycle when neither is blocked, each acting independently.
REQ-028 SHALL return old data when a read and a write target the same address in one cycle; there is no write-to-read bypass.
REQ-029 SHALL evaluate full and empty from pre-edge values when gating the access at that edge.

Reset
REQ-030 SHALL, while arst_n=0 and regardless of rclk, force read_ptr=0 and data_out=0.
REQ-031 SHALL not reset memory contents.
REQ-032 SHALL ignore rd_en and wr_en while arst_n=0.
REQ-033 SHALL release reset on the first rclk edge after arst_n rises; the empty/full outputs then follow wrt_ptr.
REQ-034 SHALL, on reset mid-operation, immediately drop read_ptr to 0; with wrt_ptr=0 this gives empty=1.

Verification
REQ-035 SHALL be verified for reset: arst_n=0, wrt_ptr=0 -> read_ptr=0, data_out=0, empty=1, full=0.
REQ-036 SHALL be verified for ordered write/read: write 0xA1 at wrt_ptr 0, set wrt_ptr=1, rd_en=1 -> after one edge data_out=0xA1, read_ptr=1, empty=1.
REQ-037 SHALL be verified for fill: write 8 words 0x10..0x17 with wrt_ptr stepping 0..7, then wrt_ptr=8 -> full=1; a further write of 0xFF leaves mem[0]=0x10.
REQ-038 SHALL be verified for drain: from the full state of REQ-037, 8 reads -> data_out sequence 0x10..0x17, then empty=1; a ninth read leaves data_out=0x17 and read_ptr=8.
REQ-039 SHALL be verified for wrap: read_ptr=15, wrt_ptr=0 with data present -> after one read, read_ptr=0, the MSB toggles, and empty=1.
REQ-040 SHALL be verified for reset mid-stream: arst_n pulsed low after 3 reads -> read_ptr=0 and data_out=0 immediately, without waiting for an rclk edge.
